sim_step_scheduler: RTL and testbench

Central phase sequencer for the multi-core rope/cloth simulation. It drives every `core` instance through one simulation step: a Verlet position update, then `num_iters` constraint-relaxation iterations, then a boundary-exchange phase that latches each core's first/last node positions into its neighbours. A phase advances only when every core has acknowledged it. The block sits at top level, beside the core array, and replaces free-running per-core control rotation.

---
 rtl/sim_step_scheduler.sv | 179 +++++++++++++++++
 tb/tb_sim_step_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_step_scheduler.sv
// Phase sequencer: drives all cores through Verlet -> N constraint passes -> boundary exchange per step.
// Optional macro SCHED_PERF_EN adds perf_cycles, the cycle length of the last completed step.
module sim_step_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int ITER_W    = 4,
  parameter int STEP_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic [ITER_W-1:0]    num_iters,
  input  logic [NUM_CORES-1:0] core_ack,
  output logic                 verlet_go,
  output logic                 constraint_go,
  output logic                 parity,
  output logic                 exch_go,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_W-1:0]    step_count,
  output logic [ITER_W-1:0]    iter_idx,
`ifdef SCHED_PERF_EN
  output logic [31:0]          perf_cycles,
`endif
  output logic [2:0]           phase
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VERLET = 3'd1,
    S_CONS   = 3'd2,
    S_EXCH   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [NUM_CORES-1:0]  ack_mask, ack_mask_n;
  logic                  verlet_go_n, cons_go_n, exch_go_n, parity_n;
  logic                  stop_pending, stop_pending_n;
  logic [ITER_W-1:0]     iter_n, iters_lat, iters_lat_n;
  logic [STEP_W-1:0]     step_n, steps_lat, steps_lat_n, step_inc;
  logic                  in_phase, phase_done;

  // Handshake: a go pulse opens a phase and clears the sticky mask in that same
  // cycle; each core raises core_ack for >=1 cycle once finished. The phase is
  // complete in the first cycle where every core has acked (mask | core_ack all
  // ones) and the next phase is entered on the following edge.
  assign in_phase   = (state == S_VERLET) || (state == S_CONS) || (state == S_EXCH);
  assign phase_done = in_phase && (&(ack_mask | core_ack));
  assign step_inc   = step_count + STEP_W'(1);

  assign busy  = in_phase;
  assign done  = (state == S_FINISH);
  assign phase = state;

  always_comb begin
    state_n        = state;
    ack_mask_n     = in_phase ? (ack_mask | core_ack) : '0;
    verlet_go_n    = 1'b0;
    cons_go_n      = 1'b0;
    exch_go_n      = 1'b0;
    parity_n       = parity;
    iter_n         = iter_idx;
    step_n         = step_count;
    stop_pending_n = stop_pending | (stop & in_phase);
    steps_lat_n    = steps_lat;
    iters_lat_n    = iters_lat;
    case (state)
      S_IDLE: begin
        stop_pending_n = 1'b0;
        if (start) begin
          state_n     = S_VERLET;
          verlet_go_n = 1'b1;
          step_n      = '0;
          iter_n      = '0;
          parity_n    = 1'b0;
          steps_lat_n = num_steps;
          iters_lat_n = (num_iters == '0) ? ITER_W'(1) : num_iters;
        end
      end
      S_VERLET: begin
        if (phase_done) begin
          state_n    = S_CONS;
          cons_go_n  = 1'b1;
          ack_mask_n = '0;
          iter_n     = '0;
          parity_n   = 1'b0;
        end
      end
      S_CONS: begin
        if (phase_done) begin
          ack_mask_n = '0;
          if (!parity) begin
            parity_n  = 1'b1;
            cons_go_n = 1'b1;
          end else if (iter_idx < (iters_lat - ITER_W'(1))) begin
            iter_n    = iter_idx + ITER_W'(1);
            parity_n  = 1'b0;
            cons_go_n = 1'b1;
          end else begin
            state_n   = S_EXCH;
            exch_go_n = 1'b1;
          end
        end
      end
      S_EXCH: begin
        if (phase_done) begin
          ack_mask_n = '0;
          step_n     = step_inc;
          // A stop raised in this very cycle still ends the run after this step.
          if (stop_pending || stop || ((steps_lat != '0) && (step_inc == steps_lat))) begin
            state_n = S_FINISH;
          end else begin
            state_n     = S_VERLET;
            verlet_go_n = 1'b1;
          end
        end
      end
      S_FINISH: begin
        state_n        = S_IDLE;
        stop_pending_n = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      ack_mask      <= '0;
      verlet_go     <= 1'b0;
      constraint_go <= 1'b0;
      exch_go       <= 1'b0;
      parity        <= 1'b0;
      iter_idx      <= '0;
      step_count    <= '0;
      stop_pending  <= 1'b0;
      steps_lat     <= '0;
      iters_lat     <= ITER_W'(1);
    end else begin
      state         <= state_n;
      ack_mask      <= ack_mask_n;
      verlet_go     <= verlet_go_n;
      constraint_go <= cons_go_n;
      exch_go       <= exch_go_n;
      parity        <= parity_n;
      iter_idx      <= iter_n;
      step_count    <= step_n;
      stop_pending  <= stop_pending_n;
      steps_lat     <= steps_lat_n;
      iters_lat     <= iters_lat_n;
    end
  end

`ifdef SCHED_PERF_EN
  // perf_cnt reads 1 in the verlet_go cycle, so at EXCH completion it holds the inclusive step length.
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (verlet_go_n) begin
        perf_cnt <= 32'd1;
      end else if (in_phase && (perf_cnt != 32'hFFFF_FFFF)) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
      if ((state == S_EXCH) && phase_done) begin
        perf_cycles <= perf_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Scoreboard bench for sim_step_scheduler: expected go/done events are queued per run and
// popped by a negedge monitor that also checks the spacing between consecutive events.
module tb_sim_step_scheduler;
  localparam int NC = 4;
  localparam int IW = 4;
  localparam int SW = 32;
  localparam int EW = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic [IW-1:0] num_iters = '0;
  logic [NC-1:0] core_ack = '0;
  logic          verlet_go, constraint_go, parity, exch_go, busy, done;
  logic [SW-1:0] step_count;
  logic [IW-1:0] iter_idx;
  logic [2:0]    phase;
`ifdef SCHED_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  sim_step_scheduler #(.NUM_CORES(NC), .ITER_W(IW), .STEP_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .num_steps     (num_steps),
    .num_iters     (num_iters),
    .core_ack      (core_ack),
    .verlet_go     (verlet_go),
    .constraint_go (constraint_go),
    .parity        (parity),
    .exch_go       (exch_go),
    .busy          (busy),
    .done          (done),
    .step_count    (step_count),
    .iter_idx      (iter_idx),
`ifdef SCHED_PERF_EN
    .perf_cycles   (perf_cycles),
`endif
    .phase         (phase)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int ack_mode = 0;
  int exp_gap = 0;
  int last_cyc = -1;
  int ack_cnt[NC] = '{default: -1};
  int dup_cnt = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 1 verlet, 2 constraint, 3 exchange, 4 done
  function automatic logic [EW-1:0] ev(input int kind, input int par, input int it, input int st);
    return {3'(kind), 1'(par), 4'(it), 32'(st)};
  endfunction

  task automatic push_run(input int n, input int iters);
    for (int s = 0; s < n; s++) begin
      exp_q.push_back(ev(1, 0, 0, s));
      for (int it = 0; it < iters; it++) begin
        exp_q.push_back(ev(2, 0, it, s));
        exp_q.push_back(ev(2, 1, it, s));
      end
      exp_q.push_back(ev(3, 1, iters - 1, s));
    end
    exp_q.push_back(ev(4, 0, 0, n));
  endtask

  // ---------------- core ack driver ----------------
  // mode 0: all cores ack the cycle after go; mode 1: core 3 five cycles later
  // plus a duplicate core 0 ack; mode 2: all cores ack in the go cycle.
  always @(posedge clk) begin
    #1;
    if (verlet_go || constraint_go || exch_go) begin
      for (int i = 0; i < NC; i++) begin
        ack_cnt[i] = (ack_mode == 2) ? 0 : ((ack_mode == 1 && i == NC - 1) ? 6 : 1);
      end
      dup_cnt = (ack_mode == 1) ? 3 : -1;
    end
    core_ack = '0;
    for (int i = 0; i < NC; i++) begin
      if (ack_cnt[i] == 0) core_ack[i] = 1'b1;
      if (ack_cnt[i] >= 0) ack_cnt[i]--;
    end
    if (dup_cnt == 0) core_ack[0] = 1'b1;
    if (dup_cnt >= 0) dup_cnt--;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    logic [2:0]    kind;
    int            nh;
    if (reset && (verlet_go || constraint_go || exch_go || done)) begin
      nh = int'(verlet_go) + int'(constraint_go) + int'(exch_go) + int'(done);
      check("one_event_per_cycle", 64'(nh), 64'd1);
      kind = done ? 3'd4 : (exch_go ? 3'd3 : (constraint_go ? 3'd2 : 3'd1));
      if (kind == 3'd2 || kind == 3'd3) act = {kind, parity, iter_idx, step_count};
      else act = {kind, 1'b0, 4'b0, step_count};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", act, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(act), 64'(e));
      end
      if (last_cyc >= 0) check("phase_gap", 64'(cyc - last_cyc), 64'(exp_gap));
      last_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int steps, input int iters, input int mode, input int gap,
                           input int n_exp, input int iters_eff);
    ack_mode  = mode;
    exp_gap   = gap;
    last_cyc  = -1;
    num_steps = SW'(steps);
    num_iters = IW'(iters);
    push_run(n_exp, iters_eff);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("verlet_go_after_start", 64'(verlet_go), 64'd1);
  endtask

  task automatic wait_done(input int exp_steps);
    int seen;
    seen = 0;
    for (int i = 0; i < 3000 && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_low_after_done", 64'(busy), 64'd0);
    check("phase_idle_after_done", 64'(phase), 64'd0);
    check("step_count_final", 64'(step_count), 64'(exp_steps));
    exp_q.delete();
  endtask

  task automatic wait_cons(input int want_step, input string name);
    int hit;
    hit = 0;
    for (int i = 0; i < 2000 && hit == 0; i++) begin
      @(negedge clk);
      if (step_count == SW'(want_step) && phase == 3'd2) hit = 1;
    end
    check(name, 64'(hit), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, 64'(phase), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_gos"}, 64'({verlet_go, constraint_go, exch_go}), 64'd0);
    check({tag, "_parity"}, 64'(parity), 64'd0);
    check({tag, "_step_count"}, 64'(step_count), 64'd0);
    check({tag, "_iter_idx"}, 64'(iter_idx), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    #2;
    check_all_zero("reset");
    #20;
    @(negedge clk);
    reset = 1'b1;

    // 2 steps x 3 iterations, acks one cycle after each go
    start_run(2, 3, 0, 2, 2, 3);
    wait_done(2);

    // staggered core 3, duplicate core 0 ack, start pulse while busy is ignored
    start_run(1, 2, 1, 7, 1, 2);
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1);

    // num_iters = 0 behaves as a single iteration
    start_run(2, 0, 0, 2, 2, 1);
    wait_done(2);

    // free-running run stopped mid-CONS of step 4
    start_run(0, 2, 0, 2, 4, 2);
    wait_cons(3, "stop_window");
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_done(4);

    // asynchronous reset in the middle of a constraint pass
    start_run(3, 2, 0, 2, 3, 2);
    wait_cons(0, "reset_window");
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // clean run after reset, same-cycle acks, single iteration
    start_run(1, 1, 2, 1, 1, 1);
    wait_done(1);
`ifdef SCHED_PERF_EN
    check("perf_cycles", 64'(perf_cycles), 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
